sr_flag_sched: RTL and testbench

Round-robin scheduler that shares a bank of SR-style flag registers between several requesters. Each requester issues set, reset or no-op commands against a flag index, and the block grants one command per clock. The granted command is applied to the flag bank, which exposes complementary q/qb vectors. The block sits in front of the SR flip-flop datapath and owns all writes to it, so no flag ever sees a simultaneous S=R=1 from two sources.

---
 rtl/sr_flag_sched.sv | 111 +++++++++++
 tb/tb_sr_flag_sched.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/sr_flag_sched.sv
// Round-robin scheduler granting one set/reset command per cycle onto a shared SR flag bank.
// Define SR_FLAG_TOGGLE_EN to make op 11 toggle the addressed flag instead of flagging an error.
module sr_flag_sched #(
  parameter int NREQ  = 4,
  parameter int NFLAG = 8,
  parameter int IW    = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_i,
  input  logic [2*NREQ-1:0]    op_i,
  input  logic [IW*NREQ-1:0]   idx_i,
  input  logic                 clr_all_i,
  output logic [NREQ-1:0]      gnt_o,
  output logic [NFLAG-1:0]     q_o,
  output logic [NFLAG-1:0]     qb_o,
  output logic                 err_o,
  output logic                 busy_o
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]    ptr_p1;
  logic [NREQ-1:0]  gnt_p1;
  logic [NFLAG-1:0] q_p1;
  logic             err_p1;

  logic             vld_p0;
  logic [PW-1:0]    win_p0;
  logic [PW-1:0]    ptr_nxt_p0;
  logic [1:0]       op_p0;
  logic [IW-1:0]    idx_p0;

  // Out-of-range indices are always illegal; op 11 only when toggling is not built in.
  function automatic logic illegal_cmd(input logic [1:0] op, input logic [IW-1:0] idx);
    logic bad;
    bad = (int'(idx) >= NFLAG);
`ifdef SR_FLAG_TOGGLE_EN
    return bad;
`else
    return bad || (op == 2'b11);
`endif
  endfunction

  function automatic logic [NFLAG-1:0] apply_op(input logic [NFLAG-1:0] q,
                                                input logic [1:0]       op,
                                                input logic [IW-1:0]    idx);
    logic [NFLAG-1:0] r;
    r = q;
    for (int f = 0; f < NFLAG; f++) begin
      if (int'(idx) == f) begin
        case (op)
          2'b01:   r[f] = 1'b1;
          2'b10:   r[f] = 1'b0;
`ifdef SR_FLAG_TOGGLE_EN
          2'b11:   r[f] = ~q[f];
`else
          2'b11:   r[f] = q[f];
`endif
          default: r[f] = q[f];
        endcase
      end
    end
    return r;
  endfunction

  // Stage p0: round-robin search starting at ptr, then select the winner's command.
  always_comb begin
    vld_p0 = 1'b0;
    win_p0 = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!vld_p0 && req_i[(int'(ptr_p1) + i) % NREQ]) begin
        vld_p0 = 1'b1;
        win_p0 = PW'((int'(ptr_p1) + i) % NREQ);
      end
    end
    ptr_nxt_p0 = PW'((int'(win_p0) + 1) % NREQ);
    op_p0      = op_i[2*int'(win_p0) +: 2];
    idx_p0     = idx_i[IW*int'(win_p0) +: IW];
  end

  // Stage p1: registered grant, flag bank and error pulse; clear-all outranks arbitration.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_p1 <= '0;
      gnt_p1 <= '0;
      err_p1 <= 1'b0;
      q_p1   <= '0;
    end else if (clr_all_i) begin
      gnt_p1 <= '0;
      err_p1 <= 1'b0;
      q_p1   <= '0;
    end else if (vld_p0) begin
      ptr_p1 <= ptr_nxt_p0;
      gnt_p1 <= {{(NREQ-1){1'b0}}, 1'b1} << win_p0;
      err_p1 <= illegal_cmd(op_p0, idx_p0);
      if (!illegal_cmd(op_p0, idx_p0))
        q_p1 <= apply_op(q_p1, op_p0, idx_p0);
    end else begin
      gnt_p1 <= '0;
      err_p1 <= 1'b0;
    end
  end

  assign gnt_o  = gnt_p1;
  assign q_o    = q_p1;
  assign qb_o   = ~q_p1;
  assign err_o  = err_p1;
  assign busy_o = (|req_i) || (|gnt_p1);

endmodule

// File: tb/tb_sr_flag_sched.sv
// Directed-vector bench for sr_flag_sched (8-flag main instance plus a 6-flag range instance).
module tb_sr_flag_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  req = '0;
  logic [7:0]  op = '0;
  logic [11:0] idx = '0;
  logic        clr = 1'b0;
  logic [3:0]  gnt;
  logic [7:0]  q, qb;
  logic        err, busy;

  logic [3:0]  req6 = '0;
  logic [7:0]  op6 = '0;
  logic [11:0] idx6 = '0;
  logic [3:0]  gnt6;
  logic [5:0]  q6, qb6;
  logic        err6, busy6;

  int n_vec = 0;
  int n_err = 0;

  sr_flag_sched #(.NREQ(4), .NFLAG(8), .IW(3)) dut (
    .clk(clk), .reset(reset), .req_i(req), .op_i(op), .idx_i(idx),
    .clr_all_i(clr), .gnt_o(gnt), .q_o(q), .qb_o(qb), .err_o(err), .busy_o(busy)
  );

  sr_flag_sched #(.NREQ(4), .NFLAG(6), .IW(3)) dut6 (
    .clk(clk), .reset(reset), .req_i(req6), .op_i(op6), .idx_i(idx6),
    .clr_all_i(1'b0), .gnt_o(gnt6), .q_o(q6), .qb_o(qb6), .err_o(err6), .busy_o(busy6)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset asserted mid-cycle takes effect immediately.
    #3 reset = 1'b1;
    #1;
    chk("rst_q",    32'(q),    'h00);
    chk("rst_qb",   32'(qb),   'hFF);
    chk("rst_gnt",  32'(gnt),  'h0);
    chk("rst_err",  32'(err),  'h0);
    chk("rst_busy", 32'(busy), 'h0);
    chk("rst_q6",   32'(q6),   'h00);
    #8 reset = 1'b0;
    tick();
    chk("idle_gnt", 32'(gnt), 'h0);

    // Basic set then reset of flag 5 by requester 0.
    req = 4'b0001; op[1:0] = 2'b01; idx[2:0] = 3'd5;
    tick();
    chk("set_gnt",  32'(gnt),  'h1);
    chk("set_q",    32'(q),    'h20);
    chk("set_qb",   32'(qb),   'hDF);
    chk("set_err",  32'(err),  'h0);
    chk("set_busy", 32'(busy), 'h1);
    op[1:0] = 2'b10;
    tick();
    chk("rst5_gnt", 32'(gnt), 'h1);
    chk("rst5_q",   32'(q),   'h00);
    req = 4'b0000;
    tick();
    chk("none_gnt",  32'(gnt),  'h0);
    chk("none_busy", 32'(busy), 'h0);

    // Out-of-range index on the 6-flag instance.
    req6 = 4'b0001; op6[1:0] = 2'b01; idx6[2:0] = 3'd1;
    tick();
    chk("r6_gnt", 32'(gnt6), 'h1);
    chk("r6_q",   32'(q6),   'h02);
    chk("r6_err", 32'(err6), 'h0);
    idx6[2:0] = 3'd7;
    tick();
    chk("oor_gnt", 32'(gnt6), 'h1);
    chk("oor_q",   32'(q6),   'h02);
    chk("oor_err", 32'(err6), 'h1);
    req6 = 4'b0000;
    tick();
    chk("oor_err_drop", 32'(err6), 'h0);
    chk("oor_gnt_drop", 32'(gnt6), 'h0);

    // Nop from requester 3 consumes a grant and moves ptr back to 0.
    req = 4'b1000; op = '0; idx = '0;
    tick();
    chk("nop_gnt", 32'(gnt), 'h8);
    chk("nop_q",   32'(q),   'h00);

    // Round-robin: all four requesters set flags 0..3.
    req = 4'b1111; op = 8'b01_01_01_01; idx = {3'd3, 3'd2, 3'd1, 3'd0};
    tick(); chk("rr_g0", 32'(gnt), 'h1); chk("rr_q0", 32'(q), 'h01);
    tick(); chk("rr_g1", 32'(gnt), 'h2); chk("rr_q1", 32'(q), 'h03);
    tick(); chk("rr_g2", 32'(gnt), 'h4); chk("rr_q2", 32'(q), 'h07);
    tick(); chk("rr_g3", 32'(gnt), 'h8); chk("rr_q3", 32'(q), 'h0F);
    tick(); chk("rr_g4", 32'(gnt), 'h1); chk("rr_q4", 32'(q), 'h0F);

    // Clear-all with no requests, then requester 1 sets flag 2 (ptr is 1).
    req = 4'b0000; clr = 1'b1;
    tick();
    chk("clr_q",   32'(q),   'h00);
    chk("clr_gnt", 32'(gnt), 'h0);
    clr = 1'b0; req = 4'b0010; op = 8'b00_00_01_00; idx = {3'd0, 3'd0, 3'd2, 3'd0};
    tick();
    chk("pre11_gnt", 32'(gnt), 'h2);
    chk("pre11_q",   32'(q),   'h04);

    // Op 11 on flag 2, twice (requesters 2 then 3).
    req = 4'b0100; op = 8'b00_11_00_00; idx = {3'd0, 3'd2, 3'd0, 3'd0};
    tick();
    chk("op11a_gnt", 32'(gnt), 'h4);
`ifdef SR_FLAG_TOGGLE_EN
    chk("op11a_q",   32'(q),   'h00);
    chk("op11a_err", 32'(err), 'h0);
`else
    chk("op11a_q",   32'(q),   'h04);
    chk("op11a_err", 32'(err), 'h1);
`endif
    req = 4'b0000;
    tick();
    chk("op11_err_drop", 32'(err), 'h0);
    req = 4'b1000; op = 8'b11_00_00_00; idx = {3'd2, 3'd0, 3'd0, 3'd0};
    tick();
    chk("op11b_gnt", 32'(gnt), 'h8);
    chk("op11b_q",   32'(q),   'h04);
`ifdef SR_FLAG_TOGGLE_EN
    chk("op11b_err", 32'(err), 'h0);
`else
    chk("op11b_err", 32'(err), 'h1);
`endif

    // Fill the bank from requester 0 (ptr starts at 0).
    req = 4'b0001; op = 8'b00_00_00_01; idx = '0;
    for (int k = 0; k < 8; k++) begin
      idx[2:0] = 3'(k);
      tick();
      chk("fill_gnt", 32'(gnt), 'h1);
    end
    chk("fill_q",  32'(q),  'hFF);
    chk("fill_qb", 32'(qb), 'h00);

    // Clear-all collides with requester 2; grant follows on the next edge.
    req = 4'b0100; op = 8'b00_01_00_00; idx = {3'd0, 3'd6, 3'd0, 3'd0};
    clr = 1'b1;
    tick();
    chk("coll_q",   32'(q),   'h00);
    chk("coll_gnt", 32'(gnt), 'h0);
    clr = 1'b0;
    tick();
    chk("coll2_gnt", 32'(gnt), 'h4);
    chk("coll2_q",   32'(q),   'h40);

    // Walk ptr from 3 to 2 with nops, then reset mid-operation.
    req = 4'b1111; op = '0; idx = '0;
    tick(); chk("walk_g3", 32'(gnt), 'h8);
    tick(); chk("walk_g0", 32'(gnt), 'h1);
    tick(); chk("walk_g1", 32'(gnt), 'h2);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_gnt",  32'(gnt),  'h0);
    chk("mid_rst_q",    32'(q),    'h00);
    chk("mid_rst_busy", 32'(busy), 'h1);
    tick();
    chk("in_rst_gnt", 32'(gnt), 'h0);
    #3 reset = 1'b0;
    tick();
    chk("post_rst_gnt", 32'(gnt), 'h1);
    tick();
    chk("post_rst_gnt2", 32'(gnt), 'h2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
